// File: rtl/bellmanford_pkg.sv
// Shared constants and FSM encoding for the bellmanford core and its result streamer.
package bellmanford_pkg;

  localparam int BF_ADDR_WIDTH = 13;
  localparam int BF_DATA_WIDTH = 16;
  localparam int BF_NUM_NODES  = 8192;
  localparam logic [BF_DATA_WIDTH-1:0] BF_INF_VALUE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_NEG,
    ST_DONE
  } bf_state_e;

endpackage

// File: rtl/bellmanford_result_streamer_if.sv
// Valid/ready record stream carrying one Output Memory entry (or the negative-cycle flag).
interface bellmanford_result_streamer_if
  import bellmanford_pkg::*;
#(
  parameter int ADDR_WIDTH = BF_ADDR_WIDTH,
  parameter int DATA_WIDTH = BF_DATA_WIDTH
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_unreachable;
  logic                  out_negcycle;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_index, out_unreachable, out_negcycle, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_unreachable, out_negcycle, out_last,
    output out_ready
  );

endinterface

// File: rtl/bellmanford_result_streamer_out_reg.sv
// bf_out_reg: one-entry valid/ready output register; a load may coincide with consumption.
module bf_out_reg
  import bellmanford_pkg::*;
#(
  parameter int ADDR_WIDTH = BF_ADDR_WIDTH,
  parameter int DATA_WIDTH = BF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [ADDR_WIDTH-1:0] ld_index,
  input  logic                  ld_unreachable,
  input  logic                  ld_negcycle,
  input  logic                  ld_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  unreachable,
  output logic                  negcycle,
  output logic                  last
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  unreachable_q, unreachable_d;
  logic                  negcycle_q, negcycle_d;
  logic                  last_q, last_d;

  // Payload only changes on a load, so it stays stable while the consumer stalls.
  always_comb begin
    valid_d       = valid_q & ~ready;
    data_d        = data_q;
    index_d       = index_q;
    unreachable_d = unreachable_q;
    negcycle_d    = negcycle_q;
    last_d        = last_q;
    if (load) begin
      valid_d       = 1'b1;
      data_d        = ld_data;
      index_d       = ld_index;
      unreachable_d = ld_unreachable;
      negcycle_d    = ld_negcycle;
      last_d        = ld_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q       <= 1'b0;
      data_q        <= '0;
      index_q       <= '0;
      unreachable_q <= 1'b0;
      negcycle_q    <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      data_q        <= data_d;
      index_q       <= index_d;
      unreachable_q <= unreachable_d;
      negcycle_q    <= negcycle_d;
      last_q        <= last_d;
    end
  end

  assign valid       = valid_q;
  assign data        = data_q;
  assign index       = index_q;
  assign unreachable = unreachable_q;
  assign negcycle    = negcycle_q;
  assign last        = last_q;

endmodule

// File: rtl/bellmanford_result_streamer.sv
// Drains the bellmanford Output Memory as a record stream on Finish, or emits a single
// negative-cycle record on NegCycle.
module bellmanford_result_streamer
  import bellmanford_pkg::*;
#(
  parameter int                    ADDR_WIDTH = BF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = BF_DATA_WIDTH,
  parameter int                    NUM_NODES  = BF_NUM_NODES,
  parameter logic [DATA_WIDTH-1:0] INF_VALUE  = BF_INF_VALUE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    Finish,
  input  logic                    NegCycle,
  output logic [ADDR_WIDTH-1:0]   OMAR,
  input  logic [DATA_WIDTH-1:0]   OMDR,
  bellmanford_result_streamer_if.master out_if,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     unreach_count
);

  localparam logic [ADDR_WIDTH:0] NUM_IDX  = (ADDR_WIDTH+1)'(NUM_NODES);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(NUM_NODES - 1);

  bf_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   unreach_q, unreach_d;
  logic                  finish_prev_q, finish_prev_d;
  logic                  neg_prev_q, neg_prev_d;

  logic                  finish_rise, neg_rise, accept;
  logic                  load;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [ADDR_WIDTH-1:0] ld_index;
  logic                  ld_negcycle, ld_last;

  assign finish_rise = Finish & ~finish_prev_q;
  assign neg_rise    = NegCycle & ~neg_prev_q;
  assign accept      = out_if.out_valid & out_if.out_ready;

  // idx carries one extra bit so it can sit at NUM_NODES after the final load without wrapping.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    unreach_d     = unreach_q;
    finish_prev_d = Finish;
    neg_prev_d    = NegCycle;
    load          = 1'b0;
    ld_data       = OMDR;
    ld_index      = idx_q[ADDR_WIDTH-1:0];
    ld_negcycle   = 1'b0;
    ld_last       = (idx_q == LAST_IDX);

    if (accept && out_if.out_unreachable && (unreach_q != NUM_IDX))
      unreach_d = unreach_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (neg_rise)
          state_d = ST_NEG;
        else if (finish_rise)
          state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if ((!out_if.out_valid || accept) && (idx_q < NUM_IDX)) begin
          load  = 1'b1;
          idx_d = idx_q + 1'b1;
        end
        if (accept && out_if.out_last)
          state_d = ST_DONE;
      end
      ST_NEG: begin
        ld_data     = '0;
        ld_index    = '0;
        ld_negcycle = 1'b1;
        ld_last     = 1'b1;
        load        = ~out_if.out_valid;
        if (accept)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      unreach_q     <= '0;
      finish_prev_q <= 1'b0;
      neg_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      unreach_q     <= unreach_d;
      finish_prev_q <= finish_prev_d;
      neg_prev_q    <= neg_prev_d;
    end
  end

  bf_out_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clock          (clock),
    .reset          (reset),
    .load           (load),
    .ld_data        (ld_data),
    .ld_index       (ld_index),
    .ld_unreachable (ld_data == INF_VALUE),
    .ld_negcycle    (ld_negcycle),
    .ld_last        (ld_last),
    .ready          (out_if.out_ready),
    .valid          (out_if.out_valid),
    .data           (out_if.out_data),
    .index          (out_if.out_index),
    .unreachable    (out_if.out_unreachable),
    .negcycle       (out_if.out_negcycle),
    .last           (out_if.out_last)
  );

  assign OMAR          = idx_q[ADDR_WIDTH-1:0];
  assign busy          = (state_q == ST_STREAM) | (state_q == ST_NEG);
  assign done          = (state_q == ST_DONE);
  assign unreach_count = unreach_q;

endmodule

// File: tb/tb_bellmanford_result_streamer.sv
// Scoreboard bench: expected records are queued from a memory model, a monitor pops on each accept.
module tb_bellmanford_result_streamer;
  import bellmanford_pkg::*;

  localparam int N   = BF_NUM_NODES;
  localparam int AW  = BF_ADDR_WIDTH;
  localparam int DW  = BF_DATA_WIDTH;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] index;
    logic          unr;
    logic          neg;
    logic          last;
  } rec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          Finish;
  logic          NegCycle;
  logic [AW-1:0] OMAR;
  logic [DW-1:0] OMDR;
  logic          busy;
  logic          done;
  logic [AW:0]   unreach_count;

  logic [DW-1:0] mem [0:N-1];
  rec_t          exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            acc_count = 0;
  int            ready_mode = 0;
  int            exp_unreach = 0;

  bellmanford_result_streamer_if bus ();

  bellmanford_result_streamer dut (
    .clock         (clock),
    .reset         (reset),
    .Finish        (Finish),
    .NegCycle      (NegCycle),
    .OMAR          (OMAR),
    .OMDR          (OMDR),
    .out_if        (bus),
    .busy          (busy),
    .done          (done),
    .unreach_count (unreach_count)
  );

  assign OMDR = mem[OMAR];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accept and checks that a stalled record holds still.
  rec_t          snap;
  logic [AW-1:0] snap_omar;
  logic          stall_prev = 1'b0;
  always @(negedge clock) begin
    rec_t got, want;
    got.data  = bus.out_data;
    got.index = bus.out_index;
    got.unr   = bus.out_unreachable;
    got.neg   = bus.out_negcycle;
    got.last  = bus.out_last;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!bus.out_valid || got !== snap || OMAR !== snap_omar) begin
          errors++;
          $display("[TB] FAIL stall_hold: got v=%b rec=%h omar=%0d, required v=1 rec=%h omar=%0d",
                   bus.out_valid, got, OMAR, snap, snap_omar);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        acc_count++;
        if (exp_q.size() == 0) begin
          check_value("unexpected_record", {19'd0, got.index}, 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          checks++;
          if (got !== want) begin
            errors++;
            $display("[TB] FAIL record: got data=%h idx=%0d unr=%b neg=%b last=%b, required data=%h idx=%0d unr=%b neg=%b last=%b",
                     got.data, got.index, got.unr, got.neg, got.last,
                     want.data, want.index, want.unr, want.neg, want.last);
          end
        end
      end
      stall_prev = bus.out_valid & ~bus.out_ready;
      snap       = got;
      snap_omar  = OMAR;
    end
  end

  task automatic fill_mem(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0, 1:    mem[i] = DW'(i * 3);
        default: mem[i] = ($urandom_range(0, 15) == 0) ? BF_INF_VALUE : DW'($urandom);
      endcase
    end
    if (mode == 1) begin
      mem[5]   = BF_INF_VALUE;
      mem[N-1] = BF_INF_VALUE;
    end
    if (mode == 2) mem[7] = BF_INF_VALUE;
  endtask

  // Reference model: the stream is simply every memory word in index order.
  task automatic push_expected();
    rec_t r;
    exp_unreach = 0;
    for (int i = 0; i < N; i++) begin
      r.data  = mem[i];
      r.index = AW'(i);
      r.unr   = (mem[i] == BF_INF_VALUE);
      r.neg   = 1'b0;
      r.last  = (i == N - 1);
      if (r.unr) exp_unreach++;
      exp_q.push_back(r);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; Finish = 1'b0; NegCycle = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_stream(input string name, input int neg_at, input bit check_timing);
    int cnt = 0;
    int first_valid = -1;
    push_expected();
    @(posedge clock); #1 Finish = 1'b1;
    while (cnt < 4 * N + 100) begin
      @(posedge clock); #1;
      cnt++;
      if (cnt == neg_at) NegCycle = 1'b1;
      if (cnt == neg_at + 2) NegCycle = 1'b0;
      @(negedge clock);
      if (bus.out_valid && first_valid < 0) first_valid = cnt;
      if (done) break;
    end
    check_value({name, "_done_reached"}, 32'(done), 32'd1);
    if (check_timing) begin
      check_value({name, "_first_valid_cycle"}, 32'(first_valid), 32'd2);
      check_value({name, "_done_cycle"}, 32'(cnt), 32'(N + 2));
    end
    check_value({name, "_unreach_count"}, 32'(unreach_count), 32'(exp_unreach));
    check_value({name, "_records_left"}, 32'(exp_q.size()), 32'd0);
    check_value({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt, first_valid, vcount;
    bit omar_moved;
    rec_t r;

    reset = 1'b1; Finish = 1'b0; NegCycle = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_value("reset_omar", 32'(OMAR), 32'd0);
    check_value("reset_valid", 32'(bus.out_valid), 32'd0);
    check_value("reset_data", 32'(bus.out_data), 32'd0);
    check_value("reset_index", 32'(bus.out_index), 32'd0);
    check_value("reset_flags", {29'd0, bus.out_unreachable, bus.out_negcycle, bus.out_last}, 32'd0);
    check_value("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check_value("reset_unreach", 32'(unreach_count), 32'd0);

    $display("[TB] full scan, ready high");
    fill_mem(0);
    run_stream("scan3i", -10, 1'b1);

    $display("[TB] Finish/NegCycle re-pulsed after done");
    Finish = 1'b0;
    repeat (3) @(posedge clock);
    #1 Finish = 1'b1; NegCycle = 1'b1;
    vcount = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.out_valid) vcount++;
    end
    check_value("repulse_no_valid", 32'(vcount), 32'd0);
    check_value("repulse_done_sticky", 32'(done), 32'd1);

    $display("[TB] unreachable entries, NegCycle during stream");
    do_reset();
    fill_mem(1);
    run_stream("inf", 50, 1'b1);

    $display("[TB] random ready");
    do_reset();
    fill_mem(2);
    ready_mode = 1;
    run_stream("rand", -10, 1'b0);
    ready_mode = 0;

    $display("[TB] simultaneous NegCycle and Finish");
    do_reset();
    r.data = '0; r.index = '0; r.unr = 1'b0; r.neg = 1'b1; r.last = 1'b1;
    exp_q.push_back(r);
    @(posedge clock); #1 Finish = 1'b1; NegCycle = 1'b1;
    cnt = 0; first_valid = -1; omar_moved = 1'b0;
    while (cnt < 50) begin
      @(posedge clock); #1;
      cnt++;
      @(negedge clock);
      if (OMAR != '0) omar_moved = 1'b1;
      if (bus.out_valid && first_valid < 0) first_valid = cnt;
      if (done) break;
    end
    check_value("neg_first_valid_cycle", 32'(first_valid), 32'd2);
    check_value("neg_done_cycle", 32'(cnt), 32'd3);
    check_value("neg_omar_stayed_zero", 32'(omar_moved), 32'd0);
    check_value("neg_records_left", 32'(exp_q.size()), 32'd0);
    check_value("neg_unreach", 32'(unreach_count), 32'd0);

    $display("[TB] reset mid-stream at record 100, then restart");
    do_reset();
    fill_mem(2);
    push_expected();
    acc_count = 0;
    @(posedge clock); #1 Finish = 1'b1;
    cnt = 0;
    while (cnt < 1000 && acc_count < 100) begin
      @(negedge clock);
      cnt++;
    end
    check_value("partial_reached_100", 32'(acc_count >= 100), 32'd1);
    check_value("partial_unreach_nonzero", 32'(unreach_count != '0), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1; Finish = 1'b0;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    check_value("midreset_valid", 32'(bus.out_valid), 32'd0);
    check_value("midreset_unreach", 32'(unreach_count), 32'd0);
    check_value("midreset_omar", 32'(OMAR), 32'd0);
    check_value("midreset_busy", 32'(busy), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    run_stream("restart", -10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
